// File: rtl/pipeline_id_ex_skid.sv
// ID/EX pipeline stage with valid/ready handshake and a main + skid buffer.
// ready_D depends only on registered state, so Execute back-pressure never reaches Decode combinationally.
module pipeline_id_ex_skid #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_D,
    output logic              ready_D,
    input  logic [WIDTH-1:0]  RD1_D,
    input  logic [WIDTH-1:0]  RD2_D,
    input  logic [WIDTH-1:0]  PC_D,
    input  logic [WIDTH-1:0]  ImmExt_D,
    input  logic [WIDTH-1:0]  PCP4_D,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_D,
    input  logic              RegWrite_D,
    input  logic [1:0]        ResultSrc_D,
    input  logic              MemWrite_D,
    input  logic [2:0]        PCsrc_D,
    input  logic [3:0]        ALUctrl_D,
    input  logic              ALUsrc_D,
    output logic              valid_E,
    input  logic              ready_E,
    output logic [WIDTH-1:0]  RD1_E,
    output logic [WIDTH-1:0]  RD2_E,
    output logic [WIDTH-1:0]  PC_E,
    output logic [WIDTH-1:0]  ImmExt_E,
    output logic [WIDTH-1:0]  PCP4_E,
    output logic [REG_AW-1:0] Rs1_E,
    output logic [REG_AW-1:0] Rs2_E,
    output logic [REG_AW-1:0] Rd_E,
    output logic              RegWrite_E,
    output logic [1:0]        ResultSrc_E,
    output logic              MemWrite_E,
    output logic [2:0]        PCsrc_E,
    output logic [3:0]        ALUctrl_E,
    output logic              ALUsrc_E,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CTL_W = 12;
    localparam int BW    = 5 * WIDTH + 3 * REG_AW + CTL_W;

    logic [BW-1:0]    main_q, main_d;
    logic [BW-1:0]    skid_q, skid_d;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [BW-1:0]    in_s;
    logic [CTL_W-1:0] ctl_s;
    logic             acc_s;
    logic             con_s;

    assign in_s = {RD1_D, RD2_D, PC_D, ImmExt_D, PCP4_D, Rs1_D, Rs2_D, Rd_D,
                   RegWrite_D, ResultSrc_D, MemWrite_D, PCsrc_D, ALUctrl_D, ALUsrc_D};

    assign ready_D = !skid_v_q;
    assign valid_E = main_v_q;
    assign acc_s   = valid_D & ready_D & !flush;
    assign con_s   = main_v_q & ready_E;
    assign stall_cnt = cnt_q;

    assign {RD1_E, RD2_E, PC_E, ImmExt_E, PCP4_E, Rs1_E, Rs2_E, Rd_E, ctl_s} = main_q;

    // Bubble gating: control fields read zero whenever no valid bundle is presented.
    always_comb begin
        RegWrite_E  = 1'b0;
        ResultSrc_E = 2'b00;
        MemWrite_E  = 1'b0;
        PCsrc_E     = 3'b000;
        ALUctrl_E   = 4'b0000;
        ALUsrc_E    = 1'b0;
        if (main_v_q) begin
            {RegWrite_E, ResultSrc_E, MemWrite_E, PCsrc_E, ALUctrl_E, ALUsrc_E} = ctl_s;
        end else begin
            RegWrite_E  = 1'b0;
            MemWrite_E  = 1'b0;
        end
    end

    // Next-state for both entries and the stall counter; flush drops valids but keeps data.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (main_v_q && !ready_E && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            if (!main_v_q || con_s) begin
                if (skid_v_q) begin
                    main_d   = skid_q;
                    main_v_d = 1'b1;
                    skid_v_d = 1'b0;
                end else if (acc_s) begin
                    main_d   = in_s;
                    main_v_d = 1'b1;
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (acc_s) begin
                skid_d   = in_s;
                skid_v_d = 1'b1;
            end else begin
                skid_v_d = skid_v_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= {BW{1'b0}};
            skid_q   <= {BW{1'b0}};
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_id_ex_skid.sv
// Directed self-checking bench for pipeline_id_ex_skid (stall counter built 4 bits wide).
module tb_pipeline_id_ex_skid;

    localparam int WIDTH  = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, valid_D, ready_D, valid_E, ready_E;
    logic [WIDTH-1:0]  RD1_D, RD2_D, PC_D, ImmExt_D, PCP4_D;
    logic [WIDTH-1:0]  RD1_E, RD2_E, PC_E, ImmExt_E, PCP4_E;
    logic [REG_AW-1:0] Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, Rd_E;
    logic              RegWrite_D, MemWrite_D, ALUsrc_D, RegWrite_E, MemWrite_E, ALUsrc_E;
    logic [1:0]        ResultSrc_D, ResultSrc_E;
    logic [2:0]        PCsrc_D, PCsrc_E;
    logic [3:0]        ALUctrl_D, ALUctrl_E;
    logic [CNT_W-1:0]  stall_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    pipeline_id_ex_skid #(.WIDTH(WIDTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_D(valid_D), .ready_D(ready_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .PC_D(PC_D), .ImmExt_D(ImmExt_D), .PCP4_D(PCP4_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .MemWrite_D(MemWrite_D),
        .PCsrc_D(PCsrc_D), .ALUctrl_D(ALUctrl_D), .ALUsrc_D(ALUsrc_D),
        .valid_E(valid_E), .ready_E(ready_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .ImmExt_E(ImmExt_E), .PCP4_E(PCP4_E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E), .MemWrite_E(MemWrite_E),
        .PCsrc_E(PCsrc_E), .ALUctrl_E(ALUctrl_E), .ALUsrc_E(ALUsrc_E),
        .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one decode bundle; datapath fields are derived from pc so they can be predicted.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rw,
                         input logic mw, input logic [3:0] alu);
        valid_D     = v;
        PC_D        = pc;
        RD1_D       = pc ^ 32'hDEAD_0000;
        RD2_D       = pc + 32'h0000_1000;
        ImmExt_D    = ~pc;
        PCP4_D      = pc + 32'h0000_0004;
        Rs1_D       = pc[6:2];
        Rs2_D       = pc[6:2] + 5'd1;
        Rd_D        = pc[6:2] + 5'd2;
        RegWrite_D  = rw;
        MemWrite_D  = mw;
        ALUctrl_D   = alu;
        ResultSrc_D = 2'b10;
        PCsrc_D     = 3'b101;
        ALUsrc_D    = 1'b1;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        vec_cnt++;
        if (PC_E !== exp) begin
            err_cnt++;
            $display("FAIL %s PC_E: got %h expected %h", name, PC_E, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ready_E = 1'b1;
        drive(1'b1, $urandom, 1'b1, 1'b1, 4'hF);
        step();
        drive(1'b1, $urandom, 1'b1, 1'b1, 4'hA);
        step();
        chk_bit("rst valid_E", valid_E, 1'b0);
        chk_pc("rst", 32'h0);
        chk_bit("rst RegWrite_E", RegWrite_E, 1'b0);
        chk_bit("rst ready_D", ready_D, 1'b1);
        vec_cnt++;
        if (stall_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL rst stall_cnt: got %0d expected 0", stall_cnt);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        step();
        chk_bit("post-rst ready_D", ready_D, 1'b1);
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
        ready_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], i[0], 1'b0, 4'(i + 3));
            step();
            chk_bit("stream valid_E", valid_E, 1'b1);
            chk_pc("stream", pcs[i]);
            chk_bit("stream RegWrite_E", RegWrite_E, i[0]);
            vec_cnt++;
            if (RD1_E !== (pcs[i] ^ 32'hDEAD_0000) || Rd_E !== (pcs[i][6:2] + 5'd2)
                || ALUctrl_E !== 4'(i + 3)) begin
                err_cnt++;
                $display("FAIL stream fields: RD1_E=%h Rd_E=%0d ALUctrl_E=%h for pc %h",
                         RD1_E, Rd_E, ALUctrl_E, pcs[i]);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        step();
        chk_bit("stream drain valid_E", valid_E, 1'b0);
    endtask

    task automatic test_skid();
        ready_E = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'h1);
        step();
        chk_pc("skid main", 32'h10);
        chk_bit("skid ready_D before", ready_D, 1'b1);
        drive(1'b1, 32'h14, 1'b0, 1'b1, 4'h2);
        step();
        chk_bit("skid ready_D full", ready_D, 1'b0);
        chk_pc("skid hold", 32'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        ready_E = 1'b1;
        step();
        chk_pc("skid drain", 32'h14);
        chk_bit("skid drain valid_E", valid_E, 1'b1);
        chk_bit("skid drain MemWrite_E", MemWrite_E, 1'b1);
        chk_bit("skid drain ready_D", ready_D, 1'b1);
        step();
        chk_bit("skid empty valid_E", valid_E, 1'b0);
        vec_cnt++;
        if (stall_cnt !== 4'd1) begin
            err_cnt++;
            $display("FAIL skid stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_flush();
        ready_E = 1'b0;
        drive(1'b1, 32'h20, 1'b1, 1'b1, 4'h3);
        step();
        drive(1'b1, 32'h24, 1'b1, 1'b1, 4'h4);
        step();
        chk_bit("flush pre ready_D", ready_D, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h30, 1'b1, 1'b1, 4'h5);
        step();
        chk_bit("flush valid_E", valid_E, 1'b0);
        chk_bit("flush MemWrite_E", MemWrite_E, 1'b0);
        chk_bit("flush ready_D", ready_D, 1'b1);
        chk_pc("flush data hold", 32'h20);
        vec_cnt++;
        if (stall_cnt !== 4'd2) begin
            err_cnt++;
            $display("FAIL flush stall_cnt: got %0d expected 2", stall_cnt);
        end
        flush = 1'b0;
        ready_E = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b0, 4'h6);
        step();
        chk_pc("post-flush", 32'h40);
        chk_bit("post-flush valid_E", valid_E, 1'b1);
        flush = 1'b1;
        drive(1'b1, 32'h44, 1'b1, 1'b0, 4'h7);
        step();
        chk_bit("flush+accept valid_E", valid_E, 1'b0);
        chk_pc("flush+accept drop", 32'h40);
        flush = 1'b0;
    endtask

    task automatic test_bubble();
        ready_E = 1'b1;
        drive(1'b0, 32'h60, 1'b1, 1'b1, 4'hF);
        step();
        chk_bit("bubble valid_E", valid_E, 1'b0);
        chk_bit("bubble RegWrite_E", RegWrite_E, 1'b0);
        chk_bit("bubble MemWrite_E", MemWrite_E, 1'b0);
        vec_cnt++;
        if (ALUctrl_E !== 4'h0 || ResultSrc_E !== 2'b00 || PCsrc_E !== 3'b000 || ALUsrc_E !== 1'b0) begin
            err_cnt++;
            $display("FAIL bubble ctl: ALUctrl_E=%h ResultSrc_E=%b PCsrc_E=%b ALUsrc_E=%b expected all 0",
                     ALUctrl_E, ResultSrc_E, PCsrc_E, ALUsrc_E);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready_E = 1'b0;
        drive(1'b1, 32'h50, 1'b1, 1'b0, 4'h8);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                vec_cnt++;
                if (stall_cnt !== 4'((i > 15) ? 15 : i)) begin
                    err_cnt++;
                    $display("FAIL sat stall_cnt after %0d stalls: got %0d expected %0d",
                             i, stall_cnt, (i > 15) ? 15 : i);
                end
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if (stall_cnt !== 4'd0 || valid_E !== 1'b0) begin
            err_cnt++;
            $display("FAIL sat rst: stall_cnt=%0d valid_E=%b expected 0 and 0", stall_cnt, valid_E);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_bubble();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
